// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU execution core: micro-state codes,
// opcode class / sub-op constants, ALU mode codes and jump condition codes.
// Ports: none (package).
package cpu_pkg;

  // One micro-state per clock; the surrounding CPU decodes these into bus strobes.
  typedef enum logic [4:0] {
    FETCH_PC   = 5'd0,
    FETCH_INST = 5'd1,
    NEXT       = 5'd2,
    ALU_OP     = 5'd3,
    LDI        = 5'd4,
    MOV_FETCH  = 5'd5,
    MOV_LOAD   = 5'd6,
    MOV_STORE  = 5'd7,
    JUMP       = 5'd8,
    OUT_A      = 5'd9,
    HALT       = 5'd10,
    PC_STORE   = 5'd11,
    FETCH_SP   = 5'd12,
    TMP_STORE  = 5'd13,
    TMP_JUMP   = 5'd14,
    RET        = 5'd15,
    INC_SP     = 5'd16
  } state_e;

  // opcode[7:6]
  localparam logic [1:0] CLS_MOV = 2'b00;
  localparam logic [1:0] CLS_ALU = 2'b01;
  localparam logic [1:0] CLS_SYS = 2'b10;
  localparam logic [7:0] OP_HLT  = 8'hFF;

  // Register code that addresses memory in a MOV (costs an extra operand byte).
  localparam logic [2:0] MEM_REG = 3'd7;

  // System sub-ops (op1)
  localparam logic [2:0] SYS_LDI  = 3'd0;
  localparam logic [2:0] SYS_JMP  = 3'd1;
  localparam logic [2:0] SYS_CALL = 3'd2;
  localparam logic [2:0] SYS_RET  = 3'd3;
  localparam logic [2:0] SYS_OUT  = 3'd4;

  // ALU modes (op1)
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_INC = 3'd2;
  localparam logic [2:0] ALU_DEC = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_XOR = 3'd6;
  localparam logic [2:0] ALU_NOT = 3'd7;

  // Jump conditions (op2); 5..7 are never taken
  localparam logic [2:0] JC_ALWAYS = 3'd0;
  localparam logic [2:0] JC_Z      = 3'd1;
  localparam logic [2:0] JC_NZ     = 3'd2;
  localparam logic [2:0] JC_EQ     = 3'd3;
  localparam logic [2:0] JC_NE     = 3'd4;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bundle between the execution core and the rest of the CPU.
// master = surrounding CPU (drives opcode/operands/bus data), slave = cpu_sequencer.
// Signals: opcode, rega, regb, bus_in in; state, cycle, pc, sp, alu_out, alu_cout, flags, halted out.
interface cpu_sequencer_if #(
  parameter int DATA_W = 8
);
  import cpu_pkg::*;

  logic [7:0]        opcode;
  logic [DATA_W-1:0] rega;
  logic [DATA_W-1:0] regb;
  logic [DATA_W-1:0] bus_in;
  state_e            state;
  logic [3:0]        cycle;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] sp;
  logic [DATA_W-1:0] alu_out;
  logic              alu_cout;
  logic              flag_z;
  logic              flag_eq;
  logic              halted;

  modport master (
    output opcode, rega, regb, bus_in,
    input  state, cycle, pc, sp, alu_out, alu_cout, flag_z, flag_eq, halted
  );

  modport slave (
    input  opcode, rega, regb, bus_in,
    output state, cycle, pc, sp, alu_out, alu_cout, flag_z, flag_eq, halted
  );
endinterface

// File: rtl/updown_counter.sv
// Loadable up/down counter used for PC and SP.
// Latency: one clock from load/enable to cnt_o; load has priority over enable.
// Ports: clk, rst_n (async low), en_i, up_i, load_i, load_val_i in; cnt_o out.
module updown_counter #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] cnt_o
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;

  // Wraps modulo 2**WIDTH in both directions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= up_i ? cnt_q + ONE : cnt_q - ONE;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/cpu_sequencer.sv
// Execution core: microcode sequencer, 8-bit ALU, PC and SP.
// Latency: one micro-state per clk; ALU is combinational, flags/PC/SP update on the state's clock edge.
// Ports: clk, reset (async active-low), sif (slave side of cpu_sequencer_if); no backpressure.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] SP_INIT = 8'hFF
) (
  input  logic           clk,
  input  logic           reset,
  cpu_sequencer_if.slave sif
);
  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [3:0]        cycle_q, cycle_d;
  logic              flag_z_q, flag_eq_q, halted_q;
  logic [DATA_W-1:0] pc_q, sp_q;
  logic [DATA_W:0]   alu_wide;
  logic              taken;
  logic              pc_en, pc_load, sp_en, sp_up;

  logic [1:0] op_cls;
  logic [2:0] op1, op2;
  logic       is_hlt;

  assign op_cls = sif.opcode[7:6];
  assign op1    = sif.opcode[5:3];
  assign op2    = sif.opcode[2:0];
  assign is_hlt = (sif.opcode == OP_HLT);

  // ALU: bit DATA_W carries the carry/borrow of ADD/SUB only.
  always_comb begin
    alu_wide = '0;
    case (op1)
      ALU_ADD: alu_wide = {1'b0, sif.rega} + {1'b0, sif.regb};
      ALU_SUB: alu_wide = {1'b0, sif.rega} - {1'b0, sif.regb};
      ALU_INC: alu_wide = {1'b0, sif.rega + ONE};
      ALU_DEC: alu_wide = {1'b0, sif.rega - ONE};
      ALU_AND: alu_wide = {1'b0, sif.rega & sif.regb};
      ALU_OR:  alu_wide = {1'b0, sif.rega | sif.regb};
      ALU_XOR: alu_wide = {1'b0, sif.rega ^ sif.regb};
      default: alu_wide = {1'b0, ~sif.rega};
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (op2)
      JC_ALWAYS: taken = 1'b1;
      JC_Z:      taken = flag_z_q;
      JC_NZ:     taken = !flag_z_q;
      JC_EQ:     taken = flag_eq_q;
      JC_NE:     taken = !flag_eq_q;
      default:   taken = 1'b0;
    endcase
  end

  // Next-state. FETCH_PC and FETCH_SP are shared by several sequences:
  // cycle 0 distinguishes the opcode fetch from an operand fetch, and op1
  // picks the CALL vs RET continuation after FETCH_SP.
  always_comb begin
    state_d = state_q;
    cycle_d = cycle_q + 4'd1;
    case (state_q)
      FETCH_PC: begin
        if (cycle_q == 4'd0)        state_d = FETCH_INST;
        else if (op1 == SYS_LDI)    state_d = LDI;
        else if (op1 == SYS_JMP)    state_d = JUMP;
        else                        state_d = TMP_STORE;
      end
      FETCH_INST: begin
        state_d = NEXT;
        if (is_hlt) begin
          state_d = HALT;
        end else if (op_cls == CLS_MOV) begin
          state_d = MOV_FETCH;
        end else if (op_cls == CLS_ALU) begin
          state_d = ALU_OP;
        end else if (op_cls == CLS_SYS) begin
          case (op1)
            SYS_LDI, SYS_JMP, SYS_CALL: state_d = FETCH_PC;
            SYS_RET:                    state_d = INC_SP;
            SYS_OUT:                    state_d = OUT_A;
            default:                    state_d = NEXT;
          endcase
        end
      end
      MOV_FETCH: state_d = MOV_LOAD;
      MOV_LOAD:  state_d = MOV_STORE;
      TMP_STORE: state_d = FETCH_SP;
      FETCH_SP:  state_d = (op1 == SYS_CALL) ? PC_STORE : RET;
      PC_STORE:  state_d = TMP_JUMP;
      INC_SP:    state_d = FETCH_SP;
      ALU_OP, LDI, MOV_STORE, JUMP, TMP_JUMP, RET, OUT_A: state_d = NEXT;
      NEXT: begin
        state_d = FETCH_PC;
        cycle_d = 4'd0;
      end
      HALT: begin
        state_d = HALT;
        cycle_d = cycle_q;
      end
      default: begin
        state_d = FETCH_PC;
        cycle_d = 4'd0;
      end
    endcase
  end

  // An untaken jump leaves PC alone: its operand byte was already skipped.
  assign pc_en   = (state_q == FETCH_PC) ||
                   ((state_q == MOV_FETCH) && ((op1 == MEM_REG) || (op2 == MEM_REG)));
  assign pc_load = (state_q == TMP_JUMP) || (state_q == RET) || ((state_q == JUMP) && taken);
  assign sp_en   = (state_q == TMP_JUMP) || (state_q == INC_SP);
  assign sp_up   = (state_q == INC_SP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH_PC;
      cycle_q   <= 4'd0;
      flag_z_q  <= 1'b0;
      flag_eq_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      halted_q <= (state_d == HALT);
      if (state_q == ALU_OP) begin
        flag_z_q  <= (alu_wide[DATA_W-1:0] == '0);
        flag_eq_q <= (sif.rega == sif.regb);
      end
    end
  end

  updown_counter #(.WIDTH(DATA_W), .RST_VAL({DATA_W{1'b0}})) u_pc (
    .clk        (clk),
    .rst_n      (reset),
    .en_i       (pc_en),
    .up_i       (1'b1),
    .load_i     (pc_load),
    .load_val_i (sif.bus_in),
    .cnt_o      (pc_q)
  );

  updown_counter #(.WIDTH(DATA_W), .RST_VAL(SP_INIT)) u_sp (
    .clk        (clk),
    .rst_n      (reset),
    .en_i       (sp_en),
    .up_i       (sp_up),
    .load_i     (1'b0),
    .load_val_i ({DATA_W{1'b0}}),
    .cnt_o      (sp_q)
  );

  assign sif.state    = state_q;
  assign sif.cycle    = cycle_q;
  assign sif.pc       = pc_q;
  assign sif.sp       = sp_q;
  assign sif.alu_out  = alu_wide[DATA_W-1:0];
  assign sif.alu_cout = alu_wide[DATA_W];
  assign sif.flag_z   = flag_z_q;
  assign sif.flag_eq  = flag_eq_q;
  assign sif.halted   = halted_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed instruction table, reset/halt sequences,
// and random instructions against an instruction-level reference model.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_sequencer_if sif ();

  cpu_sequencer #(.DATA_W(8), .SP_INIT(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif)
  );

  int n_vec = 0;
  int n_err = 0;

  // Instruction-level model state
  logic [7:0] m_pc, m_sp, m_alu_o;
  logic       m_z, m_eq, m_c, m_halt;

  state_e got_q[$];
  state_e exp_q[$];
  int     cyc_bad;
  logic [7:0] cap_alu;
  logic       cap_c;

  typedef struct {
    logic [7:0] op, a, b, bi, pc, sp;
    logic       z, eq;
    logic [7:0] alu;
    logic       c;
  } vec_t;
  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] m_alu(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
    int x, y, r;
    logic c;
    x = int'(a);
    y = int'(b);
    c = 1'b0;
    case (m)
      3'd0: begin r = x + y; c = (r > 255); end
      3'd1: begin r = x - y; c = (x < y); end
      3'd2: r = x + 1;
      3'd3: r = x - 1;
      3'd4: r = x & y;
      3'd5: r = x | y;
      3'd6: r = x ^ y;
      default: r = 255 - x;
    endcase
    return {c, 8'(r)};
  endfunction

  function automatic logic m_taken(input logic [2:0] cnd);
    case (cnd)
      3'd0: return 1'b1;
      3'd1: return m_z;
      3'd2: return !m_z;
      3'd3: return m_eq;
      3'd4: return !m_eq;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 8'h00; m_sp = 8'hFF; m_z = 1'b0; m_eq = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] bi);
    logic [8:0] r;
    m_pc = m_pc + 8'd1;
    if (op == 8'hFF) m_halt = 1'b1;
    else case (op[7:6])
      2'b00: if (op[5:3] == 3'd7 || op[2:0] == 3'd7) m_pc = m_pc + 8'd1;
      2'b01: begin
        r = m_alu(op[5:3], a, b);
        m_alu_o = r[7:0]; m_c = r[8];
        m_z = (r[7:0] == 8'd0); m_eq = (a == b);
      end
      2'b10: case (op[5:3])
        3'd0: m_pc = m_pc + 8'd1;
        3'd1: begin m_pc = m_pc + 8'd1; if (m_taken(op[2:0])) m_pc = bi; end
        3'd2: begin m_sp = m_sp - 8'd1; m_pc = bi; end
        3'd3: begin m_sp = m_sp + 8'd1; m_pc = bi; end
        default: ;
      endcase
      default: ;
    endcase
  endtask

  task automatic build_exp(input logic [7:0] op);
    exp_q.delete();
    exp_q.push_back(FETCH_PC); exp_q.push_back(FETCH_INST);
    if (op == 8'hFF) exp_q.push_back(HALT);
    else begin
      if (op[7:6] == 2'b01) exp_q.push_back(ALU_OP);
      else if (op[7:6] == 2'b00) begin
        exp_q.push_back(MOV_FETCH); exp_q.push_back(MOV_LOAD); exp_q.push_back(MOV_STORE);
      end else if (op[7:6] == 2'b10) case (op[5:3])
        3'd0: begin exp_q.push_back(FETCH_PC); exp_q.push_back(LDI); end
        3'd1: begin exp_q.push_back(FETCH_PC); exp_q.push_back(JUMP); end
        3'd2: begin
          exp_q.push_back(FETCH_PC); exp_q.push_back(TMP_STORE); exp_q.push_back(FETCH_SP);
          exp_q.push_back(PC_STORE); exp_q.push_back(TMP_JUMP);
        end
        3'd3: begin exp_q.push_back(INC_SP); exp_q.push_back(FETCH_SP); exp_q.push_back(RET); end
        3'd4: exp_q.push_back(OUT_A);
        default: ;
      endcase
      exp_q.push_back(NEXT);
    end
  endtask

  // Called at a falling edge with the DUT in FETCH_PC, cycle 0. Returns at the
  // falling edge after NEXT (back in FETCH_PC) or in HALT; bounded to 16 clocks.
  task automatic exec(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b, input logic [7:0] bi);
    sif.opcode = op; sif.rega = a; sif.regb = b; sif.bus_in = bi;
    got_q.delete();
    cyc_bad = 0;
    for (int n = 0; n < 16; n++) begin
      got_q.push_back(sif.state);
      if (sif.cycle !== 4'(n)) cyc_bad++;
      if (sif.state == ALU_OP) begin cap_alu = sif.alu_out; cap_c = sif.alu_cout; end
      if (sif.state == HALT) break;
      @(negedge clk);
      if (got_q[got_q.size()-1] == NEXT) break;
    end
  endtask

  task automatic cmp_seq(input string t, input logic [7:0] op);
    int idx;
    build_exp(op);
    idx = -1;
    for (int i = 0; i < 16; i++) begin
      if (i >= exp_q.size() && i >= got_q.size()) break;
      if (i >= exp_q.size() || i >= got_q.size() || got_q[i] != exp_q[i]) begin idx = i; break; end
    end
    chk({t, ".seq_first_diff"}, 32'(idx), 32'hFFFF_FFFF);
    chk({t, ".cycle_bad"}, 32'(cyc_bad), 32'd0);
  endtask

  task automatic chk_model(input string t, input logic [7:0] op);
    cmp_seq(t, op);
    chk({t, ".pc"}, 32'(sif.pc), 32'(m_pc));
    chk({t, ".sp"}, 32'(sif.sp), 32'(m_sp));
    chk({t, ".z"}, 32'(sif.flag_z), 32'(m_z));
    chk({t, ".eq"}, 32'(sif.flag_eq), 32'(m_eq));
    chk({t, ".halted"}, 32'(sif.halted), 32'(m_halt));
    if (op[7:6] == 2'b01) begin
      chk({t, ".alu"}, 32'(cap_alu), 32'(m_alu_o));
      chk({t, ".cout"}, 32'(cap_c), 32'(m_c));
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, ".state"}, 32'(sif.state), 32'(FETCH_PC));
    chk({t, ".cycle"}, 32'(sif.cycle), 32'd0);
    chk({t, ".pc"}, 32'(sif.pc), 32'h00);
    chk({t, ".sp"}, 32'(sif.sp), 32'hFF);
    chk({t, ".z"}, 32'(sif.flag_z), 32'd0);
    chk({t, ".eq"}, 32'(sif.flag_eq), 32'd0);
    chk({t, ".halted"}, 32'(sif.halted), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
    $fatal(1);
  end

  initial begin
    logic [7:0] op, a, b, bi;
    //        op     a      b      bus    pc     sp     z     eq    alu    c
    tbl[0]  = '{8'h40, 8'hFF, 8'h01, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1}; // ADD wraps
    tbl[1]  = '{8'h48, 8'h05, 8'h05, 8'h00, 8'h02, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0}; // SUB equal
    tbl[2]  = '{8'h8A, 8'h00, 8'h00, 8'h40, 8'h04, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0}; // JNZ not taken
    tbl[3]  = '{8'h89, 8'h00, 8'h00, 8'h40, 8'h40, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0}; // JZ taken
    tbl[4]  = '{8'h88, 8'h00, 8'h00, 8'h10, 8'h10, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0}; // JMP
    tbl[5]  = '{8'h90, 8'h00, 8'h00, 8'h80, 8'h80, 8'hFE, 1'b1, 1'b1, 8'h00, 1'b0}; // CALL
    tbl[6]  = '{8'h98, 8'h00, 8'h00, 8'h12, 8'h12, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0}; // RET
    tbl[7]  = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h14, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0}; // LDI
    tbl[8]  = '{8'h39, 8'h00, 8'h00, 8'h00, 8'h16, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0}; // MOV mem
    tbl[9]  = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'h17, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0}; // MOV reg
    tbl[10] = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h18, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0}; // OUT
    tbl[11] = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h19, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0}; // NOP
    tbl[12] = '{8'h88, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0}; // JMP to FF
    tbl[13] = '{8'hB0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0}; // NOP, PC wraps
    tbl[14] = '{8'h98, 8'h00, 8'h00, 8'h30, 8'h30, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0}; // RET, SP FF->00
    tbl[15] = '{8'h90, 8'h00, 8'h00, 8'h50, 8'h50, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0}; // CALL, SP 00->FF
    tbl[16] = '{8'h8B, 8'h00, 8'h00, 8'h22, 8'h22, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0}; // JEQ taken
    tbl[17] = '{8'h60, 8'hF0, 8'h0F, 8'h00, 8'h23, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0}; // AND
    tbl[18] = '{8'h8C, 8'h00, 8'h00, 8'h77, 8'h77, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0}; // JNE taken
    tbl[19] = '{8'h8F, 8'h00, 8'h00, 8'h11, 8'h79, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0}; // never-taken cond

    sif.opcode = 8'h00; sif.rega = 8'h00; sif.regb = 8'h00; sif.bus_in = 8'h00;
    reset = 1'b0;
    model_reset();
    #12;
    chk_reset("por");
    @(negedge clk);
    reset = 1'b1;
    chk({"por_release.state"}, 32'(sif.state), 32'(FETCH_PC));

    // Directed table
    for (int i = 0; i < 20; i++) begin
      exec(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].bi);
      model_step(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].bi);
      cmp_seq($sformatf("tbl%0d", i), tbl[i].op);
      chk($sformatf("tbl%0d.pc", i), 32'(sif.pc), 32'(tbl[i].pc));
      chk($sformatf("tbl%0d.sp", i), 32'(sif.sp), 32'(tbl[i].sp));
      chk($sformatf("tbl%0d.z", i), 32'(sif.flag_z), 32'(tbl[i].z));
      chk($sformatf("tbl%0d.eq", i), 32'(sif.flag_eq), 32'(tbl[i].eq));
      if (tbl[i].op[7:6] == 2'b01) begin
        chk($sformatf("tbl%0d.alu", i), 32'(cap_alu), 32'(tbl[i].alu));
        chk($sformatf("tbl%0d.cout", i), 32'(cap_c), 32'(tbl[i].c));
      end
    end

    // Set both flags, then abort a CALL in its NEXT state with reset.
    exec(8'h48, 8'h09, 8'h09, 8'h00);
    model_step(8'h48, 8'h09, 8'h09, 8'h00);
    chk_model("pre_abort", 8'h48);
    sif.opcode = 8'h90; sif.bus_in = 8'hA5;
    repeat (7) @(negedge clk);
    chk("mid_call.state", 32'(sif.state), 32'(NEXT));
    chk("mid_call.sp", 32'(sif.sp), 32'(m_sp - 8'd1));
    #2 reset = 1'b0;
    #1 chk_reset("mid_call_reset");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    exec(8'h80, 8'h00, 8'h00, 8'h00);
    model_step(8'h80, 8'h00, 8'h00, 8'h00);
    chk_model("after_reset_ldi", 8'h80);

    // Random instructions (HLT excluded) against the model
    for (int i = 0; i < 200; i++) begin
      op = 8'($urandom_range(0, 254));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      bi = 8'($urandom);
      exec(op, a, b, bi);
      model_step(op, a, b, bi);
      chk_model($sformatf("rnd%0d_op%02h", i, op), op);
    end

    // HALT: halted rises on entry, everything frozen afterwards
    sif.opcode = 8'hFF;
    @(negedge clk);
    chk("halt.fetch_inst_state", 32'(sif.state), 32'(FETCH_INST));
    chk("halt.pre_halted", 32'(sif.halted), 32'd0);
    @(negedge clk);
    model_step(8'hFF, 8'h00, 8'h00, 8'h00);
    chk("halt.state", 32'(sif.state), 32'(HALT));
    chk("halt.halted", 32'(sif.halted), 32'd1);
    chk("halt.pc", 32'(sif.pc), 32'(m_pc));
    repeat (10) @(negedge clk);
    chk("halt10.state", 32'(sif.state), 32'(HALT));
    chk("halt10.pc", 32'(sif.pc), 32'(m_pc));
    chk("halt10.sp", 32'(sif.sp), 32'(m_sp));
    chk("halt10.z", 32'(sif.flag_z), 32'(m_z));
    chk("halt10.eq", 32'(sif.flag_eq), 32'(m_eq));
    chk("halt10.halted", 32'(sif.halted), 32'd1);

    reset = 1'b0;
    #1 chk_reset("final_reset");
    @(negedge clk);
    reset = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
